// File: rtl/rx_pkg.sv
// Shared types and constants for the RX write scheduler: state encoding,
// default geometry and frame-buffer address widths.
package rx_pkg;

    localparam int ADDR_W             = 24;
    localparam int FB_ADDR_W          = 17;
    localparam int FB_SUM_W           = 18;
    localparam int PIXELS_PER_PKT_DEF = 320;
    localparam int FB_DEPTH_DEF       = 76800;
    localparam int AUDIO_DEPTH_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE,
        PIXELS,
        AUDIO,
        DROP
    } rx_state_e;

    // Operands are both below FB_DEPTH, so one conditional subtract suffices.
    function automatic logic [FB_SUM_W-1:0] fb_wrap(input logic [FB_SUM_W-1:0] sum,
                                                    input logic [FB_SUM_W-1:0] depth);
        return (sum >= depth) ? (sum - depth) : sum;
    endfunction

endpackage

// File: rtl/rx_audio_fifo.sv
// Count-based synchronous FIFO for audio bytes; a push while full succeeds
// only when a pop happens in the same cycle, otherwise drop_o flags the loss.
module rx_audio_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o  = (count_q == '0);
        full     = (count_q == FULL_CNT);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full || do_pop);
        drop_o   = push_i && !do_push;
        head_o   = mem_q[rd_ptr_q];
        wr_ptr_d = do_push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/rx_write_scheduler.sv
// Routes a packet's pixel bytes to the frame-buffer write port and its audio
// bytes into a FIFO. Define RX_STATS_EN to add saturating packet/error/drop counters.
module rx_write_scheduler
    import rx_pkg::*;
#(
    parameter int unsigned PIXELS_PER_PKT = PIXELS_PER_PKT_DEF,
    parameter int unsigned FB_DEPTH       = FB_DEPTH_DEF,
    parameter int unsigned AUDIO_DEPTH    = AUDIO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_active,
    input  logic        addr_valid,
    input  logic [23:0] addr,
    input  logic        pixel_valid,
    input  logic [7:0]  pixel,
    input  logic        audio_valid,
    input  logic [7:0]  audio,
    output logic        fb_we,
    output logic [16:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        aud_valid,
    output logic [7:0]  aud_data,
    input  logic        aud_ready,
    output logic        pkt_done,
    output logic        pkt_err
`ifdef RX_STATS_EN
    ,
    output logic [15:0] stat_pkts,
    output logic [15:0] stat_errs,
    output logic [15:0] stat_aud_drop
`endif
);

    localparam int unsigned CNT_W = $clog2(PIXELS_PER_PKT + 1);
    localparam logic [CNT_W-1:0]    PIX_LAST = CNT_W'(PIXELS_PER_PKT - 1);
    localparam logic [CNT_W-1:0]    PIX_FULL = CNT_W'(PIXELS_PER_PKT);
    localparam logic [ADDR_W-1:0]   DEPTH_A  = ADDR_W'(FB_DEPTH);
    localparam logic [FB_SUM_W-1:0] DEPTH_S  = FB_SUM_W'(FB_DEPTH);

    rx_state_e            state_q, state_d;
    logic                 pkt_active_q;
    logic [FB_ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic                 sticky_q, sticky_d;
    logic                 fb_we_q, fb_we_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]           fb_data_q, fb_data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 pkt_fall;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 fifo_drop;
    logic [FB_SUM_W-1:0]  wr_sum;

    assign pkt_fall  = pkt_active_q && !pkt_active;
    assign wr_sum    = FB_SUM_W'(base_q) + FB_SUM_W'(pix_cnt_q);
    // Kept outside the FSM block so the FIFO drop feedback is not a comb loop.
    assign fifo_push = (state_q == AUDIO) && audio_valid && !addr_valid;
    assign fifo_pop  = aud_valid && aud_ready;
    assign aud_valid = !fifo_empty;

    rx_audio_fifo #(
        .DEPTH (AUDIO_DEPTH),
        .WIDTH (8)
    ) u_audio_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .data_i  (audio),
        .pop_i   (fifo_pop),
        .head_o  (aud_data),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        pix_cnt_d = pix_cnt_q;
        sticky_d  = sticky_q;
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (addr_valid) begin
                    base_d    = FB_ADDR_W'(addr % DEPTH_A);
                    pix_cnt_d = '0;
                    sticky_d  = 1'b0;
                    state_d   = PIXELS;
                end
            end
            PIXELS: begin
                if (addr_valid) begin
                    state_d = DROP;
                end else if (pixel_valid) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = FB_ADDR_W'(fb_wrap(wr_sum, DEPTH_S));
                    fb_data_d = pixel;
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    if (pix_cnt_q == PIX_LAST) begin
                        state_d = AUDIO;
                    end
                end
            end
            AUDIO: begin
                if (addr_valid) begin
                    state_d = DROP;
                end else if (pixel_valid) begin
                    sticky_d = 1'b1;
                end
            end
            DROP: begin
            end
            default: state_d = IDLE;
        endcase

        if (fifo_drop) begin
            sticky_d = 1'b1;
        end

        if (pkt_fall && (state_q != IDLE)) begin
            done_d   = 1'b1;
            err_d    = (state_d == DROP) || sticky_d || (pix_cnt_d < PIX_FULL);
            state_d  = IDLE;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pkt_active_q <= 1'b0;
            base_q       <= '0;
            pix_cnt_q    <= '0;
            sticky_q     <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pkt_active_q <= pkt_active;
            base_q       <= base_d;
            pix_cnt_q    <= pix_cnt_d;
            sticky_q     <= sticky_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;
    assign pkt_done = done_q;
    assign pkt_err  = err_q;

`ifdef RX_STATS_EN
    logic [15:0] stat_pkts_q;
    logic [15:0] stat_errs_q;
    logic [15:0] stat_drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkts_q <= '0;
            stat_errs_q <= '0;
            stat_drop_q <= '0;
        end else begin
            if (done_q && (stat_pkts_q != '1)) begin
                stat_pkts_q <= stat_pkts_q + 16'd1;
            end
            if (err_q && (stat_errs_q != '1)) begin
                stat_errs_q <= stat_errs_q + 16'd1;
            end
            if (fifo_drop && (stat_drop_q != '1)) begin
                stat_drop_q <= stat_drop_q + 16'd1;
            end
        end
    end

    assign stat_pkts     = stat_pkts_q;
    assign stat_errs     = stat_errs_q;
    assign stat_aud_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_rx_write_scheduler.sv
// Directed scoreboard bench for rx_write_scheduler: expected frame-buffer
// writes and audio bytes are queued at stimulus time and checked on output.
module tb_rx_write_scheduler;

    localparam int unsigned FBD = 76800;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_active;
    logic        addr_valid;
    logic [23:0] addr;
    logic        pixel_valid;
    logic [7:0]  pixel;
    logic        audio_valid;
    logic [7:0]  audio;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data;
    logic        aud_valid;
    logic [7:0]  aud_data;
    logic        aud_ready;
    logic        pkt_done;
    logic        pkt_err;
`ifdef RX_STATS_EN
    logic [15:0] stat_pkts;
    logic [15:0] stat_errs;
    logic [15:0] stat_aud_drop;
`endif

    typedef struct {
        logic [16:0] a;
        logic [7:0]  d;
        int unsigned due;
    } fb_exp_t;

    fb_exp_t     fbq[$];
    logic [7:0]  audq[$];
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    rx_write_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_active  (pkt_active),
        .addr_valid  (addr_valid),
        .addr        (addr),
        .pixel_valid (pixel_valid),
        .pixel       (pixel),
        .audio_valid (audio_valid),
        .audio       (audio),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .aud_valid   (aud_valid),
        .aud_data    (aud_data),
        .aud_ready   (aud_ready),
        .pkt_done    (pkt_done),
        .pkt_err     (pkt_err)
`ifdef RX_STATS_EN
        ,
        .stat_pkts     (stat_pkts),
        .stat_errs     (stat_errs),
        .stat_aud_drop (stat_aud_drop)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every write / audio handshake must match the queue head.
    always @(negedge clk) begin
        fb_exp_t e;
        if (fb_we === 1'b1) begin
            vectors++;
            assert (fbq.size() != 0) else begin
                miscompares++;
                $error("FAIL fb_unexpected: observed write addr 0x%0h data 0x%0h, expected no write",
                       fb_addr, fb_data);
            end
            if (fbq.size() != 0) begin
                e = fbq.pop_front();
                chk("fb_addr", 32'(fb_addr), 32'(e.a));
                chk("fb_data", 32'(fb_data), 32'(e.d));
                chk("fb_latency", cyc, e.due);
            end
        end
        if (aud_valid === 1'b1 && aud_ready === 1'b1) begin
            vectors++;
            assert (audq.size() != 0) else begin
                miscompares++;
                $error("FAIL aud_unexpected: observed byte 0x%0h, expected no audio", aud_data);
            end
            if (audq.size() != 0) begin
                chk("aud_data", 32'(aud_data), 32'(audq.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_addr(input logic [23:0] a);
        tick();
        pkt_active = 1'b1;
        addr_valid = 1'b1;
        addr       = a;
        tick();
        addr_valid = 1'b0;
    endtask

    task automatic send_pixels(input int unsigned n, input int unsigned base,
                               input int unsigned first, input bit expect_wr);
        fb_exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            pixel_valid = 1'b1;
            pixel       = 8'(first + i);
            if (expect_wr) begin
                e.a   = 17'((base + i) % FBD);
                e.d   = 8'(first + i);
                e.due = cyc + 1;
                fbq.push_back(e);
            end
        end
        tick();
        pixel_valid = 1'b0;
    endtask

    task automatic send_audio(input int unsigned n, input int unsigned first,
                              input int unsigned keep_max);
        int unsigned kept = 0;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            audio_valid = 1'b1;
            audio       = 8'(first + i);
            if (kept < keep_max) begin
                audq.push_back(8'(first + i));
                kept++;
            end
        end
        tick();
        audio_valid = 1'b0;
    endtask

    task automatic end_pkt(input logic exp_err, input string tag);
        bit found = 0;
        tick();
        pkt_active = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (pkt_done === 1'b1) begin
                found = 1;
                chk({tag, "_err"}, 32'(pkt_err), 32'(exp_err));
            end
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL %s_done: observed no pkt_done within 8 cycles, expected one", tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        pkt_active = 1'b0;
        addr_valid = 1'b0;
        addr = '0;
        pixel_valid = 1'b0;
        pixel = '0;
        audio_valid = 1'b0;
        audio = '0;
        aud_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_data", 32'(fb_data), 32'd0);
        chk("rst_aud_valid", 32'(aud_valid), 32'd0);
        chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        chk("rst_pkt_err", 32'(pkt_err), 32'd0);
        rst = 1'b0;

        // Strobes in IDLE must be ignored.
        send_pixels(3, 0, 8'hAA, 0);
        send_audio(2, 8'h55, 0);

        // Nominal packet with audio, including push->aud_valid latency.
        send_addr(24'h000010);
        send_pixels(320, 16, 0, 1);
        tick();
        audio_valid = 1'b1;
        audio       = 8'hA0;
        audq.push_back(8'hA0);
        @(negedge clk);
        chk("aud_empty_before", 32'(aud_valid), 32'd0);
        tick();
        audio_valid = 1'b0;
        @(negedge clk);
        chk("aud_latency_valid", 32'(aud_valid), 32'd1);
        chk("aud_latency_data", 32'(aud_data), 32'hA0);
        send_audio(3, 8'hA1, 3);
        end_pkt(1'b0, "t1");
        repeat (3) tick();
        chk("t1_fb_left", fbq.size(), 32'd0);
        chk("t1_aud_left", audq.size(), 32'd0);

        // Address wrap at the end of the frame buffer.
        send_addr(24'd76790);
        send_pixels(320, 76790, 8'h40, 1);
        end_pkt(1'b0, "t2");

        // Short packet; start address above FB_DEPTH folds back.
        send_addr(24'(FBD + 32));
        send_pixels(100, 32, 7, 1);
        end_pkt(1'b1, "t3");
        tick();
        chk("t3_fb_left", fbq.size(), 32'd0);

        // Audio overflow with the consumer stalled.
        send_addr(24'd0);
        send_pixels(320, 0, 0, 1);
        aud_ready = 1'b0;
        send_audio(10, 8'h80, 8);
        end_pkt(1'b1, "t4");
        chk("t4_aud_held", 32'(aud_valid), 32'd1);
`ifdef RX_STATS_EN
        chk("t4_stat_aud_drop", 32'(stat_aud_drop), 32'd2);
`endif
        tick();
        aud_ready = 1'b1;
        repeat (12) tick();
        chk("t4_aud_left", audq.size(), 32'd0);
        chk("t4_aud_drained", 32'(aud_valid), 32'd0);

        // Second address mid-packet drops the rest.
        send_addr(24'd100);
        send_pixels(10, 100, 0, 1);
        tick();
        addr_valid = 1'b1;
        addr       = 24'd5;
        tick();
        addr_valid = 1'b0;
        send_pixels(20, 0, 0, 0);
        end_pkt(1'b1, "t5");

        // Reset mid-packet, then a clean packet.
        send_addr(24'd200);
        send_pixels(50, 200, 0, 1);
        @(negedge clk);
        chk("t6_fb_we_pre", 32'(fb_we), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_fb_we_rst", 32'(fb_we), 32'd0);
        repeat (2) tick();
        pkt_active = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_done", 32'(pkt_done), 32'd0);
        end
        chk("t6_fb_left", fbq.size(), 32'd0);
        send_addr(24'd300);
        send_pixels(320, 300, 8'h11, 1);
        end_pkt(1'b0, "t6b");
        repeat (3) tick();
`ifdef RX_STATS_EN
        chk("t6_stat_pkts", 32'(stat_pkts), 32'd1);
        chk("t6_stat_errs", 32'(stat_errs), 32'd0);
`endif
        chk("end_fb_left", fbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
